rotary_decoder_mc: RTL and testbench
====================================

# rotary_decoder_mc

Multi-channel quadrature decoder, the parametrised successor to the single-channel rotary encoder front end. Each channel synchronises and debounces the two active-low encoder outputs and decodes full Gray-code quadrature, so both rotation directions and illegal jumps are detected. Quarter-steps are grouped into detents, and each detent produces a one-cycle up or down pulse for the LED controller. An optional signed position counter per channel is also available.

## Interface
- `CHANNELS`, 2: number of independent encoders (1–8).
- `DEBOUNCE_CYCLES`, 40000: required stable cycles before a debounced input changes (1 ms at 40 MHz); 0 = debounce bypassed.
- `STEPS_PER_DETENT`, 4: quarter-steps per output pulse; legal values 1, 2, 4.
- `COUNT_W`, 8: position counter width per channel.

Ports:
- `clk`  in  1  40 MHz clock.
- `res_n`  in  1  reset, asynchronous assert, active-low.
- `rotary_clk`  in  CHANNELS  encoder "clk" outputs, active low, asynchronous.
- `rotary_dt`  in  CHANNELS  encoder "dt" outputs, active low, asynchronous.
- `rotation_up`  out  CHANNELS  one-cycle pulse per clockwise detent.
- `rotation_dn`  out  CHANNELS  one-cycle pulse per counter-clockwise detent.
- `rotation_err`  out  CHANNELS  one-cycle pulse on an illegal quadrature transition.
- `position`  out  CHANNELS*COUNT_W  signed per-channel detent count; channel n occupies bits [n*COUNT_W +: COUNT_W].

## Operation
Per-channel pipeline; channels are fully independent, and simultaneous events on different channels are all reported in the same cycle.

- **Synchroniser:** 2-flop synchroniser per input. Reset value 1 (inactive). Invert after synchronising: A = ~clk_sync, B = ~dt_sync (active high).
- **Debounce:** per input, a counter of width clog2(DEBOUNCE_CYCLES+1).
  - Counter clears whenever the synced value equals the debounced value.
  - Otherwise it increments.
  - When it reaches DEBOUNCE_CYCLES, the debounced value takes the synced value and the counter clears.
- **Startup:** a block-wide 2-bit counter runs for 3 cycles after `res_n` deasserts.
  - During startup, the debounced value loads the synced value directly.
  - Decode is suppressed: no pulses and no errors.
- **Decode:** compare the previous {A,B} with the current debounced {A,B} each cycle.
  - Up sequence: 00→01→11→10→00, meaning dt asserts before clk.
  - Reverse sequence = down.
  - No change = idle.
  - Both bits changing in one cycle = illegal: `rotation_err` pulses, the accumulator clears, and no step or position change occurs.
- **Detent accumulator:** signed, range −(S−1)..(S−1), where S = STEPS_PER_DETENT.
  - Up quarter-step at acc = S−1: `rotation_up` pulses and acc ← 0; otherwise acc+1.
  - Down quarter-step at acc = −(S−1): `rotation_dn` pulses and acc ← 0; otherwise acc−1.
  - With S = 1, every quarter-step pulses.
  - A reversal mid-detent walks the accumulator back without emitting a pulse.
- **Position:** +1 on each `rotation_up`, −1 on each `rotation_dn`. Two's complement, wraps modulo 2^COUNT_W; 0x7F+1 = 0x80 at COUNT_W = 8.

## Timing
- **Reset values:** every output is 0; debounced state 00; accumulators 0; debounce counters 0.
- **Reset mid-operation:**
  - Assertion clears all state and outputs immediately, regardless of `clk`.
  - Any partial detent is discarded.
  - On release, startup applies: the current encoder levels are adopted silently, even at a non-00 position.
- **Latency:** an input level first sampled at edge 0 and held stable produces its pulse at edge DEBOUNCE_CYCLES+3, or edge 3 when bypassed.
- **Glitches:** a glitch shorter than DEBOUNCE_CYCLES synced cycles produces no event.
- **Pulse width:** `rotation_up`, `rotation_dn` and `rotation_err` are registered, exactly 1 cycle wide, and mutually exclusive per channel.
- **Position timing:** `position` updates in the same cycle the pulse is high.
- **Throughput:** at most one quarter-step per channel per cycle after debounce.

## Configuration
- `ROTARY_POSITION_EN` defined: position counters are built and behave as in Operation.
- Not defined:
  - No counter flops are built.
  - `position` is tied to 0.
  - All other behaviour is identical.

## Test plan
Bench settings: CHANNELS=2, DEBOUNCE_CYCLES=4, STEPS_PER_DETENT=4, COUNT_W=8, `ROTARY_POSITION_EN` defined. All waits are in clock cycles.
- **Clockwise detent:** ch0 {clk,dt} driven 11→10→00→01→11 (active-low levels), 20 cycles per step.
  - Exactly one `rotation_up[0]` pulse, 7 cycles after the final edge.
  - `position[7:0]` = 0x01; ch1 quiet.
- **Counter-clockwise ×3:** three CCW detents on ch1 → three `rotation_dn[1]` pulses; `position[15:8]` = 0xFD.
- **Glitch rejection and reversal:**
  - A 3-cycle low glitch on `rotary_clk[0]` → no pulse.
  - Two CW quarter-steps followed by two CCW → no pulse, position unchanged.
- **Illegal jump:** ch0 both lines toggled in the same cycle (11→00) → one `rotation_err[0]` pulse, no up/dn, accumulator cleared.
- **Simultaneous and wrap:**
  - Preload ch0 to 127 detents CW, then CW on ch0 and CCW on ch1 aligned.
  - Both pulses fire in the same cycle; `position[7:0]` = 0x80.
- **Async reset mid-detent:**
  - Assert `res_n` low between edges after two quarter-steps → all outputs 0 immediately.
  - Release with inputs at 00 → no pulse or error.
  - A next full CW detent produces exactly one up pulse.

Source files
------------

// File: rtl/rotary_decoder_mc.sv
// Multi-channel quadrature decoder: sync, debounce, Gray decode, detent grouping.
// Define ROTARY_POSITION_EN to build the per-channel signed position counters.
module rotary_decoder_mc #(
   parameter int unsigned CHANNELS         = 2,
   parameter int unsigned DEBOUNCE_CYCLES  = 40000,
   parameter int unsigned STEPS_PER_DETENT = 4,
   parameter int unsigned COUNT_W          = 8
) (
   input  logic                        clk,
   input  logic                        res_n,
   input  logic [CHANNELS-1:0]         rotary_clk,
   input  logic [CHANNELS-1:0]         rotary_dt,
   output logic [CHANNELS-1:0]         rotation_up,
   output logic [CHANNELS-1:0]         rotation_dn,
   output logic [CHANNELS-1:0]         rotation_err,
   output logic [CHANNELS*COUNT_W-1:0] position
);

   localparam int unsigned CntW = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
   localparam logic [CntW-1:0]   CntMax = CntW'(DEBOUNCE_CYCLES);
   localparam logic signed [2:0] AccMax = 3'(STEPS_PER_DETENT - 1);
   localparam logic signed [2:0] AccMin = -AccMax;

   // Startup window: adopt current encoder levels silently for 3 cycles after reset.
   logic [1:0] start_cnt_q;
   logic       startup;

   assign startup = (start_cnt_q != 2'd3);

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         start_cnt_q <= '0;
      end else if (startup) begin
         start_cnt_q <= start_cnt_q + 2'd1;
      end
   end

   for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
      logic [1:0]        sync_clk_q, sync_dt_q;
      logic [1:0]        sync_ab;
      logic [1:0]        deb_q, deb_d, prev_q;
      logic [CntW-1:0]   cnt_q [2];
      logic [CntW-1:0]   cnt_d [2];
      logic [1:0]        phase_prev, phase_cur, phase_diff;
      logic signed [2:0] acc_q, acc_d;
      logic              up_q, up_d, dn_q, dn_d, err_q, err_d;

      assign sync_ab = {~sync_clk_q[1], ~sync_dt_q[1]};

      always_comb begin
         deb_d = deb_q;
         for (int i = 0; i < 2; i++) begin
            cnt_d[i] = '0;
            if (startup) begin
               deb_d[i] = sync_ab[i];
            end else if (sync_ab[i] != deb_q[i]) begin
               if (cnt_q[i] == CntMax) begin
                  deb_d[i] = sync_ab[i];
               end else begin
                  cnt_d[i] = cnt_q[i] + CntW'(1);
               end
            end
         end
      end

      // Phase index along the up sequence 00,01,11,10 -> 0,1,2,3
      assign phase_prev = {prev_q[1], ^prev_q};
      assign phase_cur  = {deb_q[1], ^deb_q};
      assign phase_diff = phase_cur - phase_prev;

      always_comb begin
         acc_d = acc_q;
         up_d  = 1'b0;
         dn_d  = 1'b0;
         err_d = 1'b0;
         if (!startup) begin
            case (phase_diff)
               2'd1: begin
                  if (acc_q == AccMax) begin
                     up_d  = 1'b1;
                     acc_d = '0;
                  end else begin
                     acc_d = acc_q + 3'sd1;
                  end
               end
               2'd3: begin
                  if (acc_q == AccMin) begin
                     dn_d  = 1'b1;
                     acc_d = '0;
                  end else begin
                     acc_d = acc_q - 3'sd1;
                  end
               end
               2'd2: begin
                  err_d = 1'b1;
                  acc_d = '0;
               end
               default: ;
            endcase
         end
      end

      always_ff @(posedge clk or negedge res_n) begin
         if (!res_n) begin
            sync_clk_q <= 2'b11;
            sync_dt_q  <= 2'b11;
            deb_q      <= '0;
            prev_q     <= '0;
            cnt_q[0]   <= '0;
            cnt_q[1]   <= '0;
            acc_q      <= '0;
            up_q       <= 1'b0;
            dn_q       <= 1'b0;
            err_q      <= 1'b0;
         end else begin
            sync_clk_q <= {sync_clk_q[0], rotary_clk[ch]};
            sync_dt_q  <= {sync_dt_q[0], rotary_dt[ch]};
            deb_q      <= deb_d;
            // Track the adopted level during startup so no transition is seen afterwards
            prev_q     <= startup ? deb_d : deb_q;
            cnt_q[0]   <= cnt_d[0];
            cnt_q[1]   <= cnt_d[1];
            acc_q      <= acc_d;
            up_q       <= up_d;
            dn_q       <= dn_d;
            err_q      <= err_d;
         end
      end

      assign rotation_up[ch]  = up_q;
      assign rotation_dn[ch]  = dn_q;
      assign rotation_err[ch] = err_q;

`ifdef ROTARY_POSITION_EN
      logic [COUNT_W-1:0] pos_q;

      always_ff @(posedge clk or negedge res_n) begin
         if (!res_n) begin
            pos_q <= '0;
         end else if (up_d) begin
            pos_q <= pos_q + COUNT_W'(1);
         end else if (dn_d) begin
            pos_q <= pos_q - COUNT_W'(1);
         end
      end

      assign position[ch*COUNT_W +: COUNT_W] = pos_q;
`else
      assign position[ch*COUNT_W +: COUNT_W] = '0;
`endif
   end

endmodule

// File: tb/tb_rotary_decoder_mc.sv
// Self-checking bench for rotary_decoder_mc: vector table, corner sequences and
// randomized traffic against a detent-level reference model.
module tb_rotary_decoder_mc;

   localparam int unsigned Ch  = 2;
   localparam int unsigned Deb = 4;
   localparam int unsigned Spd = 4;
   localparam int unsigned Cw  = 8;

   logic          clk = 1'b0;
   logic          res_n;
   logic [Ch-1:0] rotary_clk, rotary_dt;
   logic [Ch-1:0] up, dn, err;
   logic [15:0]   position;

   int checks = 0;
   int failures = 0;

   rotary_decoder_mc #(
      .CHANNELS         (Ch),
      .DEBOUNCE_CYCLES  (Deb),
      .STEPS_PER_DETENT (Spd),
      .COUNT_W          (Cw)
   ) dut (
      .clk          (clk),
      .res_n        (res_n),
      .rotary_clk   (rotary_clk),
      .rotary_dt    (rotary_dt),
      .rotation_up  (up),
      .rotation_dn  (dn),
      .rotation_err (err),
      .position     (position)
   );

   initial forever #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog");
   end

   typedef struct {
      int         ch;
      logic [1:0] lv;
      int         n_up;
      int         n_dn;
      int         n_err;
      int         lat;
      int         p0;
      int         p1;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input int ch, input logic [1:0] lv, input int nu, input int nd,
                               input int ne, input int lat, input int p0, input int p1);
      vec_t v;
      v.ch = ch; v.lv = lv; v.n_up = nu; v.n_dn = nd; v.n_err = ne;
      v.lat = lat; v.p0 = p0; v.p1 = p1;
      vecs.push_back(v);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] expp(input int p);
`ifdef ROTARY_POSITION_EN
      return 32'(p & 255);
`else
      return 32'd0;
`endif
   endfunction

   // Position of active-low {clk,dt} levels along the clockwise cycle
   function automatic int qpos(input logic [1:0] lv);
      case (~lv)
         2'b00:   return 0;
         2'b01:   return 1;
         2'b11:   return 2;
         default: return 3;
      endcase
   endfunction

   // Drive one level, observe `hold` cycles; lat is the edge index of the first event on ch
   task automatic run_step(input int ch, input logic [1:0] lv, input int hold,
                           output int nu, output int nd, output int ne, output int no,
                           output int lat);
      nu = 0; nd = 0; ne = 0; no = 0; lat = -1;
      rotary_clk[ch] = lv[1];
      rotary_dt[ch]  = lv[0];
      for (int i = 1; i <= hold; i++) begin
         @(negedge clk);
         if (up[ch]) nu++;
         if (dn[ch]) nd++;
         if (err[ch]) ne++;
         if ((up[ch] | dn[ch] | err[ch]) && lat < 0) lat = i - 1;
         if (up[1-ch] | dn[1-ch] | err[1-ch]) no++;
      end
   endtask

   initial begin
      int         nu, nd, ne, no, lat, tot, nev, t0, t1, c0, c1, extra;
      logic [1:0] cw_seq [4];
      logic [1:0] ccw_seq [4];
      logic [1:0] lvl [2];
      int         acc [2];
      int         mpos [2];
      int         pend_due [2];
      int         pend_kind [2];
      int         since [2];
      int         gap [2];

      cw_seq  = '{2'b10, 2'b00, 2'b01, 2'b11};
      ccw_seq = '{2'b01, 2'b00, 2'b10, 2'b11};

      rotary_clk = '1;
      rotary_dt  = '1;
      res_n = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_up", 32'(up), 0);
      check("reset_dn", 32'(dn), 0);
      check("reset_err", 32'(err), 0);
      check("reset_pos", 32'(position), 0);
      res_n = 1'b1;
      repeat (10) @(negedge clk);

      // Clockwise detent on ch0
      add(0, 2'b10, 0, 0, 0, -1, 0, 0);
      add(0, 2'b00, 0, 0, 0, -1, 0, 0);
      add(0, 2'b01, 0, 0, 0, -1, 0, 0);
      add(0, 2'b11, 1, 0, 0, 7, 1, 0);
      // Three counter-clockwise detents on ch1
      for (int k = 1; k <= 3; k++) begin
         add(1, 2'b01, 0, 0, 0, -1, 1, -(k - 1));
         add(1, 2'b00, 0, 0, 0, -1, 1, -(k - 1));
         add(1, 2'b10, 0, 0, 0, -1, 1, -(k - 1));
         add(1, 2'b11, 0, 1, 0, 7, 1, -k);
      end
      // Reversal mid-detent
      add(0, 2'b10, 0, 0, 0, -1, 1, -3);
      add(0, 2'b00, 0, 0, 0, -1, 1, -3);
      add(0, 2'b10, 0, 0, 0, -1, 1, -3);
      add(0, 2'b11, 0, 0, 0, -1, 1, -3);
      // Illegal jumps; the clear is visible through where the next up pulse lands
      add(0, 2'b10, 0, 0, 0, -1, 1, -3);
      add(0, 2'b01, 0, 0, 1, 7, 1, -3);
      add(0, 2'b11, 0, 0, 0, -1, 1, -3);
      add(0, 2'b10, 0, 0, 0, -1, 1, -3);
      add(0, 2'b00, 0, 0, 0, -1, 1, -3);
      add(0, 2'b01, 1, 0, 0, 7, 2, -3);
      add(0, 2'b11, 0, 0, 0, -1, 2, -3);
      add(0, 2'b00, 0, 0, 1, 7, 2, -3);
      add(0, 2'b11, 0, 0, 1, 7, 2, -3);

      foreach (vecs[i]) begin
         run_step(vecs[i].ch, vecs[i].lv, 20, nu, nd, ne, no, lat);
         check($sformatf("vec%0d_up", i), nu, vecs[i].n_up);
         check($sformatf("vec%0d_dn", i), nd, vecs[i].n_dn);
         check($sformatf("vec%0d_err", i), ne, vecs[i].n_err);
         check($sformatf("vec%0d_other", i), no, 0);
         check($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
         check($sformatf("vec%0d_pos0", i), 32'(position[7:0]), expp(vecs[i].p0));
         check($sformatf("vec%0d_pos1", i), 32'(position[15:8]), expp(vecs[i].p1));
      end

      // Short glitch on rotary_clk[0]
      rotary_clk[0] = 1'b0;
      repeat (3) @(negedge clk);
      rotary_clk[0] = 1'b1;
      nev = 0;
      repeat (20) begin
         @(negedge clk);
         if (|{up, dn, err}) nev++;
      end
      check("glitch_events", nev, 0);
      check("glitch_pos0", 32'(position[7:0]), expp(2));

      // Preload ch0 to 127 detents
      tot = 0;
      for (int d = 0; d < 125; d++) begin
         for (int k = 0; k < 4; k++) begin
            run_step(0, cw_seq[k], 10, nu, nd, ne, no, lat);
            tot += nu;
         end
      end
      check("preload_ups", tot, 125);
      check("preload_pos0", 32'(position[7:0]), expp(127));

      // Aligned CW on ch0 and CCW on ch1
      t0 = -1; t1 = -1; c0 = 0; c1 = 0; extra = 0;
      for (int k = 0; k < 4; k++) begin
         rotary_clk[0] = cw_seq[k][1];
         rotary_dt[0]  = cw_seq[k][0];
         rotary_clk[1] = ccw_seq[k][1];
         rotary_dt[1]  = ccw_seq[k][0];
         for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (up[0]) begin c0++; t0 = k * 20 + i; end
            if (dn[1]) begin c1++; t1 = k * 20 + i; end
            if (dn[0] | err[0] | up[1] | err[1]) extra++;
         end
      end
      check("simul_up0", c0, 1);
      check("simul_dn1", c1, 1);
      check("simul_same_cycle", t0, t1);
      check("simul_lat", t0, 3 * 20 + 8);
      check("simul_extra", extra, 0);
      check("wrap_pos0", 32'(position[7:0]), expp(128));
      check("simul_pos1", 32'(position[15:8]), expp(-4));

      // Asynchronous reset after two quarter-steps
      run_step(0, 2'b10, 20, nu, nd, ne, no, lat);
      run_step(0, 2'b00, 20, nu, nd, ne, no, lat);
      #2;
      res_n = 1'b0;
      #1;
      check("arst_up", 32'(up), 0);
      check("arst_dn", 32'(dn), 0);
      check("arst_err", 32'(err), 0);
      check("arst_pos", 32'(position), 0);
      rotary_clk = 2'b00;
      rotary_dt  = 2'b00;
      @(negedge clk);
      res_n = 1'b1;
      nev = 0;
      repeat (30) begin
         @(negedge clk);
         if (|{up, dn, err}) nev++;
      end
      check("startup_quiet", nev, 0);
      tot = 0; c0 = 0; c1 = 0;
      for (int k = 0; k < 4; k++) begin
         run_step(0, cw_seq[(k + 2) % 4], 20, nu, nd, ne, no, lat);
         tot += nu; c0 += nd + ne; c1 += no;
      end
      check("post_rst_up", tot, 1);
      check("post_rst_other", c0 + c1, 0);
      check("post_rst_pos0", 32'(position[7:0]), expp(1));
      check("post_rst_pos1", 32'(position[15:8]), expp(0));

      // Randomized traffic against the detent model
      res_n = 1'b0;
      for (int ch = 0; ch < 2; ch++) begin
         lvl[ch] = 2'($urandom_range(0, 3));
         rotary_clk[ch] = lvl[ch][1];
         rotary_dt[ch]  = lvl[ch][0];
         acc[ch] = 0; mpos[ch] = 0; pend_due[ch] = -1; pend_kind[ch] = 0;
         since[ch] = 0; gap[ch] = 9;
      end
      @(negedge clk);
      res_n = 1'b1;
      repeat (8) @(negedge clk);
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         for (int ch = 0; ch < 2; ch++) begin
            int         kind;
            logic [2:0] exp_ev;
            kind = (pend_due[ch] == n) ? pend_kind[ch] : 0;
            if (kind == 1) mpos[ch]++;
            if (kind == 2) mpos[ch]--;
            exp_ev = (kind == 1) ? 3'b100 : (kind == 2) ? 3'b010 : (kind == 3) ? 3'b001 : 3'b000;
            check($sformatf("rnd%0d_ch%0d_ev", n, ch), 32'({up[ch], dn[ch], err[ch]}),
                  32'(exp_ev));
            check($sformatf("rnd%0d_ch%0d_pos", n, ch), 32'(position[ch*8 +: 8]),
                  expp(mpos[ch]));
            since[ch]++;
            if (n < 2980 && since[ch] >= gap[ch] && $urandom_range(0, 3) == 0) begin
               int         r, delta;
               logic [1:0] nl;
               r  = $urandom_range(0, 9);
               nl = (r >= 8) ? ~lvl[ch] : (r % 2 == 1) ? (lvl[ch] ^ 2'b01) : (lvl[ch] ^ 2'b10);
               delta = (qpos(nl) - qpos(lvl[ch]) + 4) % 4;
               pend_kind[ch] = 0;
               if (delta == 1) begin
                  if (acc[ch] == Spd - 1) begin pend_kind[ch] = 1; acc[ch] = 0; end
                  else acc[ch]++;
               end else if (delta == 3) begin
                  if (acc[ch] == -(Spd - 1)) begin pend_kind[ch] = 2; acc[ch] = 0; end
                  else acc[ch]--;
               end else begin
                  pend_kind[ch] = 3;
                  acc[ch] = 0;
               end
               pend_due[ch] = n + 8;
               lvl[ch] = nl;
               rotary_clk[ch] = nl[1];
               rotary_dt[ch]  = nl[0];
               since[ch] = 0;
               gap[ch] = $urandom_range(9, 16);
            end
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
